// File: rtl/wb_stage_if.sv
// wb_stage_if: result handshake from the memory stage into writeback.
//   in_valid    memory stage presents a result
//   in_ready    writeback can accept (driven by wb_stage)
//   in_rd       destination register
//   in_data     ALU result or raw load word
//   in_is_load  apply load alignment/extension
//   in_size     0 word, 1 halfword, 2 byte, 3 illegal
//   in_sign     sign-extend loads
//   in_addr_lo  byte offset of the load address
// master: memory stage side; slave: wb_stage side.
interface wb_stage_if #(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [REG_ADDR_LEN-1:0] in_rd;
    logic [WIDTH-1:0]        in_data;
    logic                    in_is_load;
    logic [1:0]              in_size;
    logic                    in_sign;
    logic [1:0]              in_addr_lo;

    modport master (
        output in_valid, in_rd, in_data, in_is_load, in_size, in_sign, in_addr_lo,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_data, in_is_load, in_size, in_sign, in_addr_lo,
        output in_ready
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage. Buffers formatted results in a 2-entry FIFO and
// drives the register-file write port, with a bypass lookup for decode.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_bus              result handshake (wb_stage_if.slave)
//   hold                freeze pops; pushes still accepted while space remains
//   rc, dataC, w_en     registered register-file write port
//   w_mode              constant 0 (word); extension is done here
//   qa, qb              decode source indices to look up
//   hit_a/b, fwd_a/b    youngest pending write to qa/qb (combinational)
//   misalign            one-cycle pulse after a misaligned/illegal load push
//   err_sticky          set with misalign, cleared only by rst
module wb_stage #(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_stage_if.slave               in_bus,
    input  logic                    hold,
    output logic [REG_ADDR_LEN-1:0] rc,
    output logic [WIDTH-1:0]        dataC,
    output logic                    w_en,
    output logic [1:0]              w_mode,
    input  logic [REG_ADDR_LEN-1:0] qa,
    input  logic [REG_ADDR_LEN-1:0] qb,
    output logic                    hit_a,
    output logic                    hit_b,
    output logic [WIDTH-1:0]        fwd_a,
    output logic [WIDTH-1:0]        fwd_b,
    output logic                    misalign,
    output logic                    err_sticky
);
    logic [REG_ADDR_LEN-1:0] ent_rd   [2];
    logic [WIDTH-1:0]        ent_data [2];
    logic                    ent_kill [2];

    logic [1:0] count;
    logic       head;
    logic       tail;
    logic       wr_idx;
    logic       push;
    logic       pop;

    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [WIDTH-1:0] fmt_data;
    logic             fmt_kill;

    assign in_bus.in_ready = (count != 2'd2);
    assign push   = in_bus.in_valid && in_bus.in_ready;
    assign pop    = (count != 2'd0) && !hold;
    assign tail   = ~head;
    // Next free slot: head when empty, the other slot when one entry is held.
    assign wr_idx = head ^ count[0];
    assign w_mode = '0;

    // Format at push time so FIFO entries already hold the final word.
    always_comb begin
        sel_byte = in_bus.in_data[{in_bus.in_addr_lo, 3'b000} +: 8];
        sel_half = in_bus.in_data[{in_bus.in_addr_lo[1], 4'b0000} +: 16];
        fmt_data = in_bus.in_data;
        fmt_kill = 1'b0;
        if (in_bus.in_is_load) begin
            unique case (in_bus.in_size)
                2'd0: begin
                    fmt_kill = (in_bus.in_addr_lo != 2'd0);
                end
                2'd1: begin
                    fmt_data = {{(WIDTH-16){in_bus.in_sign & sel_half[15]}}, sel_half};
                    fmt_kill = in_bus.in_addr_lo[0];
                end
                2'd2: begin
                    fmt_data = {{(WIDTH-8){in_bus.in_sign & sel_byte[7]}}, sel_byte};
                end
                default: begin
                    fmt_kill = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[wr_idx]   <= in_bus.in_rd;
            ent_data[wr_idx] <= fmt_data;
            ent_kill[wr_idx] <= fmt_kill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            head       <= 1'b0;
            w_en       <= 1'b0;
            rc         <= '0;
            dataC      <= '0;
            misalign   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            head <= head ^ pop;

            if (pop) begin
                rc    <= ent_rd[head];
                dataC <= ent_data[head];
                w_en  <= !ent_kill[head] && (ent_rd[head] != '0);
            end else begin
                w_en  <= 1'b0;
            end

            misalign   <= push && fmt_kill;
            err_sticky <= err_sticky || (push && fmt_kill);
        end
    end

    // Later matches overwrite earlier ones, so the youngest source wins:
    // output register, then FIFO head, then FIFO tail.
    function automatic logic [WIDTH:0] lookup(input logic [REG_ADDR_LEN-1:0] q);
        logic [WIDTH:0] r;
        r = '0;
        if (q != '0) begin
            if (w_en && rc == q)
                r = {1'b1, dataC};
            if (count != 2'd0 && !ent_kill[head] && ent_rd[head] == q)
                r = {1'b1, ent_data[head]};
            if (count == 2'd2 && !ent_kill[tail] && ent_rd[tail] == q)
                r = {1'b1, ent_data[tail]};
        end
        return r;
    endfunction

    assign {hit_a, fwd_a} = lookup(qa);
    assign {hit_b, fwd_b} = lookup(qb);
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage. Directed vector table for
// load formatting, hand-written hold/bypass/reset sequences, then random
// traffic against a queue-based reference model.
module tb_wb_stage;
    localparam int W = 32;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         hold;
    logic [R-1:0] rc, qa, qb;
    logic [W-1:0] dataC, fwd_a, fwd_b;
    logic         w_en, hit_a, hit_b, misalign, err_sticky;
    logic [1:0]   w_mode;

    wb_stage_if #(.WIDTH(W), .REG_ADDR_LEN(R)) bus ();

    wb_stage #(.WIDTH(W), .REG_ADDR_LEN(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_bus     (bus),
        .hold       (hold),
        .rc         (rc),
        .dataC      (dataC),
        .w_en       (w_en),
        .w_mode     (w_mode),
        .qa         (qa),
        .qb         (qb),
        .hit_a      (hit_a),
        .hit_b      (hit_b),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .misalign   (misalign),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [R-1:0] rd, input logic [31:0] d,
                          input logic ld, input logic [1:0] sz, input logic sg,
                          input logic [1:0] lo);
        bus.in_valid   = v;
        bus.in_rd      = rd;
        bus.in_data    = d;
        bus.in_is_load = ld;
        bus.in_size    = sz;
        bus.in_sign    = sg;
        bus.in_addr_lo = lo;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        hold = 1'b0;
        qa   = '0;
        qb   = '0;
        set_in(1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_w_en"}, w_en, 0);
        check({tag, "_rc"}, rc, 0);
        check({tag, "_dataC"}, dataC, 0);
        check({tag, "_misalign"}, misalign, 0);
        check({tag, "_err_sticky"}, err_sticky, 0);
        check({tag, "_w_mode"}, w_mode, 0);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [R-1:0] rd;
        logic [31:0]  data;
        logic         kill;
    } ent_t;

    ent_t         mq[$];
    logic         m_wen;
    logic [R-1:0] m_rc;
    logic [31:0]  m_data;
    logic         m_sticky;

    function automatic int unsigned access_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 4;
            2'd1:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic ref_kill(input logic ld, input logic [1:0] sz, input logic [1:0] lo);
        if (!ld) return 1'b0;
        if (sz == 2'd3) return 1'b1;
        return (int'(lo) % access_bytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_fmt(input logic [31:0] d, input logic ld,
                                            input logic [1:0] sz, input logic sg,
                                            input logic [1:0] lo);
        int unsigned nb;
        logic [31:0] mask, v;
        if (!ld || sz == 2'd0 || sz == 2'd3) return d;
        nb   = access_bytes(sz);
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = (d >> (8 * int'(lo))) & mask;
        if (sg && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic ref_lookup(input logic [R-1:0] q, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (q == '0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!mq[i].kill && mq[i].rd == q) begin
                hit = 1'b1;
                d   = mq[i].data;
                return;
            end
        end
        if (m_wen && m_rc == q) begin
            hit = 1'b1;
            d   = m_data;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [R-1:0] rd;
        logic [31:0]  data;
        logic         ld;
        logic [1:0]   sz;
        logic         sg;
        logic [1:0]   lo;
        logic [31:0]  exp_data;
        logic         exp_wen;
        logic         exp_mis;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic        hx, hy;
        logic [31:0] fx, fy;
        logic        v, ld, sg, kill, push, pop, exp_mis;
        logic [1:0]  sz, lo;
        logic [R-1:0] rd;
        logic [31:0] d;
        ent_t        e;

        vecs[0]  = '{5'd5,  32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 2'd0, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[1]  = '{5'd6,  32'h80FF7F01, 1'b1, 2'd2, 1'b1, 2'd2, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[2]  = '{5'd7,  32'h80FF7F01, 1'b1, 2'd2, 1'b0, 2'd0, 32'h00000001, 1'b1, 1'b0};
        vecs[3]  = '{5'd8,  32'h80FF7F01, 1'b1, 2'd1, 1'b1, 2'd2, 32'hFFFF80FF, 1'b1, 1'b0};
        vecs[4]  = '{5'd9,  32'h80FF7F01, 1'b1, 2'd1, 1'b1, 2'd1, 32'h00000000, 1'b0, 1'b1};
        vecs[5]  = '{5'd10, 32'h80FF7F01, 1'b1, 2'd1, 1'b0, 2'd0, 32'h00007F01, 1'b1, 1'b0};
        vecs[6]  = '{5'd11, 32'h80FF7F01, 1'b1, 2'd2, 1'b1, 2'd3, 32'hFFFFFF80, 1'b1, 1'b0};
        vecs[7]  = '{5'd12, 32'h80FF7F01, 1'b1, 2'd3, 1'b0, 2'd0, 32'h00000000, 1'b0, 1'b1};
        vecs[8]  = '{5'd13, 32'h80FF7F01, 1'b1, 2'd2, 1'b0, 2'd1, 32'h0000007F, 1'b1, 1'b0};
        vecs[9]  = '{5'd14, 32'h80FF7F01, 1'b1, 2'd0, 1'b1, 2'd2, 32'h00000000, 1'b0, 1'b1};
        vecs[10] = '{5'd15, 32'h80FF7F01, 1'b1, 2'd0, 1'b1, 2'd0, 32'h80FF7F01, 1'b1, 1'b0};
        vecs[11] = '{5'd0,  32'h12345678, 1'b0, 2'd0, 1'b0, 2'd0, 32'h12345678, 1'b0, 1'b0};
        vecs[12] = '{5'd16, 32'h0000ABCD, 1'b0, 2'd3, 1'b1, 2'd1, 32'h0000ABCD, 1'b1, 1'b0};

        do_reset();
        check_reset_state("reset");

        // One result at a time from an empty FIFO.
        for (int i = 0; i < 13; i++) begin
            set_in(1'b1, vecs[i].rd, vecs[i].data, vecs[i].ld, vecs[i].sz, vecs[i].sg, vecs[i].lo);
            qa = vecs[i].rd;
            #1;
            check($sformatf("vec%0d_ready", i), bus.in_ready, 1);
            tick();                                   // accepted
            bus.in_valid = 1'b0;
            #1;
            check($sformatf("vec%0d_misalign", i), misalign, vecs[i].exp_mis);
            check($sformatf("vec%0d_wen_before_pop", i), w_en, 0);
            check($sformatf("vec%0d_hit_pending", i), hit_a, vecs[i].exp_wen);
            if (vecs[i].exp_wen)
                check($sformatf("vec%0d_fwd_pending", i), fwd_a, vecs[i].exp_data);
            tick();                                   // popped into output regs
            check($sformatf("vec%0d_w_en", i), w_en, vecs[i].exp_wen);
            check($sformatf("vec%0d_rc", i), rc, vecs[i].rd);
            if (!vecs[i].exp_mis)
                check($sformatf("vec%0d_dataC", i), dataC, vecs[i].exp_data);
            check($sformatf("vec%0d_misalign_gone", i), misalign, 0);
            check($sformatf("vec%0d_hit_outreg", i), hit_a, vecs[i].exp_wen);
            tick();
            check($sformatf("vec%0d_w_en_drop", i), w_en, 0);
        end
        check("err_sticky_set", err_sticky, 1);

        // hold: fill to 2, stall, then drain in order.
        do_reset();
        hold = 1'b1;
        set_in(1'b1, 5'd1, 32'hA1, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        set_in(1'b1, 5'd2, 32'hB2, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        set_in(1'b1, 5'd3, 32'hC3, 1'b0, 2'd0, 1'b0, 2'd0);
        #1;
        check("hold_ready_full", bus.in_ready, 0);
        check("hold_no_wen", w_en, 0);
        tick();
        check("hold_still_full", bus.in_ready, 0);
        check("hold_still_no_wen", w_en, 0);
        hold = 1'b0;
        tick();
        check("drain0_wen", w_en, 1);
        check("drain0_rc", rc, 1);
        check("drain0_data", dataC, 32'hA1);
        tick();
        check("drain1_wen", w_en, 1);
        check("drain1_rc", rc, 2);
        check("drain1_data", dataC, 32'hB2);
        bus.in_valid = 1'b0;
        tick();
        check("drain2_wen", w_en, 1);
        check("drain2_rc", rc, 3);
        check("drain2_data", dataC, 32'hC3);
        tick();
        check("drain_done_wen", w_en, 0);
        check("drain_done_ready", bus.in_ready, 1);

        // Bypass priority with two writes to r7 and a write to r0.
        do_reset();
        hold = 1'b1;
        set_in(1'b1, 5'd7, 32'h11, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        set_in(1'b1, 5'd7, 32'h22, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        bus.in_valid = 1'b0;
        qa = 5'd7;
        qb = 5'd0;
        #1;
        check("byp_hit_a", hit_a, 1);
        check("byp_fwd_a_youngest", fwd_a, 32'h22);
        check("byp_hit_b_r0", hit_b, 0);
        check("byp_fwd_b_miss", fwd_b, 0);
        hold = 1'b0;
        set_in(1'b1, 5'd0, 32'h33, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        check("byp_w0_rc", rc, 7);
        check("byp_w0_data", dataC, 32'h11);
        check("byp_fwd_head", fwd_a, 32'h22);
        tick();
        bus.in_valid = 1'b0;
        qb = 5'd0;
        #1;
        check("byp_w1_data", dataC, 32'h22);
        check("byp_fwd_outreg", fwd_a, 32'h22);
        check("byp_r0_pending_no_hit", hit_b, 0);
        tick();
        check("byp_r0_no_wen", w_en, 0);
        check("byp_after_hit_a", hit_a, 0);

        // Reset while two entries (one killed) are buffered.
        do_reset();
        hold = 1'b1;
        set_in(1'b1, 5'd3, 32'h80FF7F01, 1'b1, 2'd1, 1'b0, 2'd1);
        tick();
        check("rst_seq_misalign", misalign, 1);
        set_in(1'b1, 5'd4, 32'h44, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        check("rst_seq_sticky", err_sticky, 1);
        check("rst_seq_misalign_once", misalign, 0);
        rst  = 1'b1;
        hold = 1'b0;
        bus.in_valid = 1'b0;
        qa = 5'd4;
        tick();
        rst = 1'b0;
        check_reset_state("midrst");
        check("midrst_hit_a", hit_a, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midrst_no_wen%0d", i), w_en, 0);
        end

        // Random traffic against the reference model.
        do_reset();
        mq.delete();
        m_wen    = 1'b0;
        m_rc     = '0;
        m_data   = '0;
        m_sticky = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v    = ($urandom_range(0, 9) < 7);
            hold = ($urandom_range(0, 3) == 0);
            rd   = R'($urandom_range(0, 7));
            d    = $urandom;
            ld   = $urandom_range(0, 1);
            sz   = 2'($urandom_range(0, 3));
            sg   = $urandom_range(0, 1);
            lo   = 2'($urandom_range(0, 3));
            qa   = R'($urandom_range(0, 7));
            qb   = R'($urandom_range(0, 7));
            set_in(v, rd, d, ld, sz, sg, lo);
            #1;
            check("rnd_in_ready", bus.in_ready, mq.size() < 2);
            ref_lookup(qa, hx, fx);
            ref_lookup(qb, hy, fy);
            check("rnd_hit_a", hit_a, hx);
            check("rnd_fwd_a", fwd_a, fx);
            check("rnd_hit_b", hit_b, hy);
            check("rnd_fwd_b", fwd_b, fy);

            kill = ref_kill(ld, sz, lo);
            push = v && (mq.size() < 2);
            pop  = (mq.size() > 0) && !hold;
            if (pop) begin
                e      = mq.pop_front();
                m_wen  = !e.kill && (e.rd != '0);
                m_rc   = e.rd;
                m_data = e.data;
            end else begin
                m_wen = 1'b0;
            end
            if (push) begin
                e.rd   = rd;
                e.data = ref_fmt(d, ld, sz, sg, lo);
                e.kill = kill;
                mq.push_back(e);
            end
            exp_mis  = push && kill;
            m_sticky = m_sticky || exp_mis;

            tick();
            check("rnd_w_en", w_en, m_wen);
            check("rnd_misalign", misalign, exp_mis);
            check("rnd_err_sticky", err_sticky, m_sticky);
            if (m_wen) begin
                check("rnd_rc", rc, m_rc);
                check("rnd_dataC", dataC, m_data);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage for MyProc2. It accepts completed ALU and load results from the memory stage over a valid/ready handshake and buffers them in a 2-entry FIFO. Load data is aligned and sign/zero-extended by access size. It drives the register file write port (`rc`, `dataC`, `w_en`, `w_mode`) and exposes a bypass lookup so decode can read results that are still pending in writeback.

## Interface
- `WIDTH`, 32, datapath width
- `REG_ADDR_LEN`, 5, register index width
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  memory stage presents a result
- `in_ready`  out  1  stage can accept; combinational, `count < 2`
- `in_rd`  in  REG_ADDR_LEN  destination register
- `in_data`  in  WIDTH  ALU result, or raw load word
- `in_is_load`  in  1  apply load alignment/extension
- `in_size`  in  2  0 word, 1 halfword, 2 byte, 3 illegal
- `in_sign`  in  1  sign-extend (loads only)
- `in_addr_lo`  in  2  byte offset of the load address
- `hold`  in  1  freeze pops (debug/stall); pushes still allowed
- `rc`  out  REG_ADDR_LEN  register-file write index (registered)
- `dataC`  out  WIDTH  register-file write data (registered)
- `w_en`  out  1  register-file write enable (registered)
- `w_mode`  out  2  tied to 0 (word); extension is done here
- `qa`, `qb`  in  REG_ADDR_LEN  decode source indices to look up
- `hit_a`, `hit_b`  out  1  pending write to `qa`/`qb` exists (combinational)
- `fwd_a`, `fwd_b`  out  WIDTH  youngest pending data for `qa`/`qb`
- `misalign`  out  1  one-cycle pulse: misaligned or illegal load accepted
- `err_sticky`  out  1  set by `misalign`, cleared only by `rst`

## Operation
- Push when `in_valid && in_ready`. Data is formatted at push time, so FIFO entries hold the final word.
- Load formatting:
  - Byte: `in_data[8*addr_lo +: 8]`.
  - Half: `in_data[16*addr_lo[1] +: 16]`.
  - Word: unchanged.
  - Sign-extend if `in_sign`, else zero-extend.
  - Non-loads pass `in_data` unchanged; `in_size`, `in_sign` and `in_addr_lo` are ignored.
- Misaligned load (half with `addr_lo[0]=1`, word with `addr_lo!=0`) or `in_size=3`:
  - Entry is pushed with its kill bit set; `misalign` pulses in the cycle after the push.
  - Killed entries are popped normally but never assert `w_en`.
- Pop: when `count>0 && !hold`, the head moves into the output registers. `w_en=1` unless the entry has `rd==0` or is killed; then `w_en=0` and `rc`/`dataC` still load.
- When there is no pop, `w_en=0`; `rc`/`dataC` hold their values.
- Push and pop in the same cycle are legal when `count` is 1 (count unchanged) or 0 (no pop, since the FIFO is empty). When `count==2`, `in_ready=0` regardless of pop.
- Bypass lookup:
  - Searches the output register (when `w_en=1`) and all valid, non-killed FIFO entries with `rd==q`, `q!=0`.
  - Priority is youngest first: FIFO tail, then head, then output register.
  - On a miss, `fwd_x=0`.
  - `q==0` never hits.
- `w_mode` is constant 0, so the register file never re-truncates.

## Timing
- Reset (`rst=1` at posedge): FIFO empties, `count=0`, `w_en=0`, `rc=0`, `dataC=0`, `misalign=0`, `err_sticky=0`. `in_ready` is 1 after reset.
- Reset mid-operation discards all buffered entries; no write is issued for them.
- Latency with an empty FIFO and `hold=0`:
  - Accept at edge N.
  - Popped at edge N+1, `w_en=1` during cycle N+1.
  - Register file written at edge N+2.
- Sustained throughput: 1 result per cycle.
- `hold` asserted: `w_en` drops at the next edge; the FIFO fills to 2, then `in_ready=0`.
- The result of a `hold` deassert is visible on `w_en` one edge later.
- Bypass outputs are combinational from current state and `qa`/`qb`. They cover the window between push and the register-file update at edge N+2.

## Test plan
- ALU result `rd=5`, `data=0xDEADBEEF`, push at edge 1 -> `w_en=1`, `rc=5`, `dataC=0xDEADBEEF` in cycle 2; `hit_a=1` for `qa=5` during cycles 1–2.
- Loads with `in_data=0x80FF7F01`:
  - Byte, `addr_lo=2`, signed -> `0xFFFFFFFF`.
  - Byte, `addr_lo=0`, unsigned -> `0x00000001`.
  - Half, `addr_lo=2`, signed -> `0xFFFF80FF`.
- Half load with `addr_lo=1` -> `misalign` pulses once, `err_sticky=1`, no `w_en` for that entry, and the following entry is written normally.
- `hold=1`, push 3 back-to-back results -> `in_ready=0` after 2. Release `hold` -> writes emerge in order on consecutive cycles, then `in_ready=1`.
- Pending writes to r7 (`0x11`, then `0x22`) plus a write to r0 -> `qa=7` gives `fwd_a=0x22`, `qa=0` gives `hit_a=0`, and r0 produces no `w_en`.
- Assert `rst` with 2 entries buffered -> no `w_en` afterwards and all outputs at their reset values.
